pipe_stage_regs: RTL

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

---
 rtl/pipe_stage_regs_pkg.sv | 46 ++++
 rtl/pipe_stage_regs_pipe_reg.sv | 21 ++
 rtl/pipe_stage_regs.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_regs_pkg.sv
// Shared types and constants for the fetch/decode/execute pipeline registers.
package pipe_stage_regs_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_IDX = 5;

  localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_C  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } forward_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_ctrl;
  } ctrl_e_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  typedef struct packed {
    ctrl_e_t            ctrl;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm_ext;
    logic [REG_IDX-1:0] rs1;
    logic [REG_IDX-1:0] rs2;
    logic [REG_IDX-1:0] rd;
    logic               valid;
  } idex_t;

endpackage

// File: rtl/pipe_stage_regs_pipe_reg.sv
// Generic pipeline register with enable and synchronous clear to a fixed bubble value.
module pipe_reg #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear beats enable so a flush always wins over a hold.
  always_ff @(posedge clk) begin
    if (!rst_n)   q <= RST_VAL;
    else if (clr) q <= RST_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// Fetch PC, IF/ID and ID/EX pipeline registers with stall/flush control and perf counters.
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_f,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               flush_e,
  input  logic               pc_src_e,
  input  logic [XLEN-1:0]    pc_target_e,
  input  logic [XLEN-1:0]    instr_f,
  input  logic [XLEN-1:0]    rd1_d,
  input  logic [XLEN-1:0]    rd2_d,
  input  logic [XLEN-1:0]    imm_ext_d,
  input  ctrl_e_t            ctrl_d,
  output logic [XLEN-1:0]    pc_f,
  output logic [XLEN-1:0]    instr_d,
  output logic [XLEN-1:0]    pc_d,
  output logic [XLEN-1:0]    pc_plus4_d,
  output logic               valid_d,
  output logic [REG_IDX-1:0] rs1_d,
  output logic [REG_IDX-1:0] rs2_d,
  output logic [REG_IDX-1:0] rd_d,
  output logic [XLEN-1:0]    pc_e,
  output logic [XLEN-1:0]    pc_plus4_e,
  output logic [XLEN-1:0]    rd1_e,
  output logic [XLEN-1:0]    rd2_e,
  output logic [XLEN-1:0]    imm_ext_e,
  output logic [REG_IDX-1:0] rs1_e,
  output logic [REG_IDX-1:0] rs2_e,
  output logic [REG_IDX-1:0] rd_e,
  output ctrl_e_t            ctrl_e,
  output logic               valid_e,
  output logic [XLEN-1:0]    stall_cnt,
  output logic [XLEN-1:0]    flush_cnt
);

  localparam int unsigned IFID_W = $bits(ifid_t);
  localparam int unsigned IDEX_W = $bits(idex_t);
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_next;
  ifid_t           ifid_d;
  ifid_t           ifid_q;
  idex_t           idex_d;
  idex_t           idex_q;

  // Redirect beats stall, stall beats sequential fetch.
  always_comb begin
    pc_plus4_f = pc_f + XLEN'(4);
    pc_next    = pc_plus4_f;
    if (pc_src_e)     pc_next = pc_target_e;
    else if (stall_f) pc_next = pc_f;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_f <= RESET_PC;
    else        pc_f <= pc_next;
  end

  assign ifid_d = '{instr: instr_f, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};

  pipe_reg #(
    .WIDTH   (IFID_W),
    .RST_VAL (IFID_W'(IFID_BUBBLE))
  ) u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall_d),
    .clr   (flush_d),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign instr_d    = ifid_q.instr;
  assign pc_d       = ifid_q.pc;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d    = ifid_q.valid;
  assign rs1_d      = ifid_q.instr[19:15];
  assign rs2_d      = ifid_q.instr[24:20];
  assign rd_d       = ifid_q.instr[11:7];

  assign idex_d = '{ctrl: ctrl_d, pc: pc_d, pc_plus4: pc_plus4_d, rd1: rd1_d, rd2: rd2_d,
                    imm_ext: imm_ext_d, rs1: rs1_d, rs2: rs2_d, rd: rd_d, valid: valid_d};

  pipe_reg #(
    .WIDTH   (IDEX_W),
    .RST_VAL ('0)
  ) u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (flush_e),
    .d     (idex_d),
    .q     (idex_q)
  );

  assign ctrl_e     = idex_q.ctrl;
  assign pc_e       = idex_q.pc;
  assign pc_plus4_e = idex_q.pc_plus4;
  assign rd1_e      = idex_q.rd1;
  assign rd2_e      = idex_q.rd2;
  assign imm_ext_e  = idex_q.imm_ext;
  assign rs1_e      = idex_q.rs1;
  assign rs2_e      = idex_q.rs2;
  assign rd_e       = idex_q.rd;
  assign valid_e    = idex_q.valid;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + XLEN'(1);
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + XLEN'(1);
    end
  end

endmodule
